// File: rtl/if_id_reg_pkg.sv
// ---------------------------------------------------------------------------
// if_id_reg_pkg
//   Shared constants for the IF/ID pipeline register and its fetch-address
//   checker: exception codes, the nop encoding, default reset PC and
//   instruction-memory geometry, and the link-address helper.
// ---------------------------------------------------------------------------
package if_id_reg_pkg;

  localparam logic [4:0]  EXC_NONE     = 5'd0;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam int unsigned DEF_IM_WORDS = 32'd4096;

  // Link value for jal/jalr: skips the delay slot. 32-bit wrap, carry dropped.
  function automatic logic [31:0] link_addr(input logic [31:0] pc);
    return pc + 32'd8;
  endfunction

endpackage

// File: rtl/fetch_exc_check.sv
// ---------------------------------------------------------------------------
// fetch_exc_check
//   Combinational instruction-fetch address check. Flags AdEL when the PC is
//   not word aligned or lies outside [IM_BASE, IM_BASE + 4*IM_WORDS).
//   Ports:
//     pc   in  32  fetch address
//     exc  out 5   EXC_NONE or EXC_ADEL
// ---------------------------------------------------------------------------
module fetch_exc_check
  import if_id_reg_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter int unsigned IM_WORDS = DEF_IM_WORDS
) (
  input  logic [31:0] pc,
  output logic [4:0]  exc
);

  // Bounds are kept 33 bits wide so a memory that ends exactly at 2^32
  // does not wrap the upper limit to zero.
  localparam logic [32:0] IM_LO = {1'b0, IM_BASE};
  localparam logic [32:0] IM_HI = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic [32:0] pc_ext;
  logic        misaligned;
  logic        out_of_range;

  assign pc_ext       = {1'b0, pc};
  assign misaligned   = (pc[1:0] != 2'b00);
  assign out_of_range = (pc_ext < IM_LO) || (pc_ext >= IM_HI);

  // Select the exception code for this fetch address.
  always_comb begin
    exc = EXC_NONE;
    if (misaligned || out_of_range) begin
      exc = EXC_ADEL;
    end else begin
      exc = EXC_NONE;
    end
  end

endmodule

// File: rtl/if_id_reg.sv
// ---------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Captures the fetched instruction and its PC,
//   precomputes PC+8, tags delay-slot and AdEL fetch exceptions, and supports
//   stall (en=0 holds) and flush (bubble). Priority: clr > flush > en.
//   Ports:
//     clk       in   1   rising-edge clock
//     clr       in   1   synchronous active-high reset
//     en        in   1   1 = load fetch, 0 = hold
//     flush     in   1   1 = load bubble
//     PC_F      in   32  fetch PC
//     instr_F   in   32  instruction read data for PC_F
//     branch_D  in   1   ID holds a branch/jump -> this fetch is its delay slot
//     instr_D   out  32  registered instruction (nop when bubble or AdEL)
//     PC_D      out  32  registered PC
//     PC8_D     out  32  registered PC+8
//     valid_D   out  1   real instruction present
//     bd_D      out  1   in branch delay slot
//     exc_D     out  5   exception code
// ---------------------------------------------------------------------------
module if_id_reg
  import if_id_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter int unsigned IM_WORDS = DEF_IM_WORDS
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] PC_F,
  input  logic [31:0] instr_F,
  input  logic        branch_D,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        valid_D,
  output logic        bd_D,
  output logic [4:0]  exc_D
);

  logic [31:0] instr_d, instr_q;
  logic [31:0] pc_d,    pc_q;
  logic [31:0] pc8_d,   pc8_q;
  logic        valid_d, valid_q;
  logic        bd_d,    bd_q;
  logic [4:0]  exc_d,   exc_q;
  logic [4:0]  fetch_exc;

  fetch_exc_check #(
    .IM_BASE  (IM_BASE),
    .IM_WORDS (IM_WORDS)
  ) u_fetch_exc_check (
    .pc  (PC_F),
    .exc (fetch_exc)
  );

  // Next-state selection: bubble on flush, load on en, otherwise hold.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
    bd_d    = bd_q;
    exc_d   = exc_q;
    if (flush) begin
      instr_d = NOP;
      pc_d    = RESET_PC;
      pc8_d   = link_addr(RESET_PC);
      valid_d = 1'b0;
      bd_d    = 1'b0;
      exc_d   = EXC_NONE;
    end else if (en) begin
      // PC is captured even on AdEL so EPC can be recovered from it.
      pc_d    = PC_F;
      pc8_d   = link_addr(PC_F);
      valid_d = 1'b1;
      bd_d    = branch_D;
      exc_d   = fetch_exc;
      if (fetch_exc != EXC_NONE) begin
        instr_d = NOP;
      end else begin
        instr_d = instr_F;
      end
    end else begin
      instr_d = instr_q;
      pc_d    = pc_q;
      pc8_d   = pc8_q;
      valid_d = valid_q;
      bd_d    = bd_q;
      exc_d   = exc_q;
    end
  end

  // Pipeline register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      instr_q <= NOP;
      pc_q    <= RESET_PC;
      pc8_q   <= link_addr(RESET_PC);
      valid_q <= 1'b0;
      bd_q    <= 1'b0;
      exc_q   <= EXC_NONE;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
      bd_q    <= bd_d;
      exc_q   <= exc_d;
    end
  end

  assign instr_D = instr_q;
  assign PC_D    = pc_q;
  assign PC8_D   = pc8_q;
  assign valid_D = valid_q;
  assign bd_D    = bd_q;
  assign exc_D   = exc_q;

endmodule

// File: tb/tb_if_id_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_reg
//   Scoreboard bench for if_id_reg: each driven cycle pushes the expected
//   register contents to a queue; after the clock edge the entry is popped
//   and compared field by field.
// ---------------------------------------------------------------------------
module tb_if_id_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
    logic        bd;
    logic [4:0]  exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] PC_F = 32'h0;
  logic [31:0] instr_F = 32'h0;
  logic        branch_D = 1'b0;
  logic [31:0] instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        valid_D;
  logic        bd_D;
  logic [4:0]  exc_D;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t model;
  exp_t sb_q[$];

  if_id_reg dut (
    .clk      (clk),
    .clr      (clr),
    .en       (en),
    .flush    (flush),
    .PC_F     (PC_F),
    .instr_F  (instr_F),
    .branch_D (branch_D),
    .instr_D  (instr_D),
    .PC_D     (PC_D),
    .PC8_D    (PC8_D),
    .valid_D  (valid_D),
    .bd_D     (bd_D),
    .exc_D    (exc_D)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle, predict the next register state, then compare after the edge.
  task automatic step(input logic c, input logic f, input logic e,
                      input logic [31:0] pc, input logic [31:0] ins, input logic br);
    exp_t nxt;
    exp_t got;
    logic bad_addr;
    clr = c; flush = f; en = e; PC_F = pc; instr_F = ins; branch_D = br;
    bad_addr = (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc >= 32'h0000_7000);
    if (c || f) begin
      nxt = '{instr: 32'h0, pc: 32'h0000_3000, pc8: 32'h0000_3008,
              valid: 1'b0, bd: 1'b0, exc: 5'd0};
    end else if (e) begin
      nxt.pc    = pc;
      nxt.pc8   = pc + 32'd8;
      nxt.valid = 1'b1;
      nxt.bd    = br;
      nxt.exc   = bad_addr ? 5'd4 : 5'd0;
      nxt.instr = bad_addr ? 32'h0 : ins;
    end else begin
      nxt = model;
    end
    model = nxt;
    sb_q.push_back(nxt);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check_val("instr_D", instr_D, got.instr);
      check_val("PC_D",    PC_D,    got.pc);
      check_val("PC8_D",   PC8_D,   got.pc8);
      check_val("valid_D", {31'd0, valid_D}, {31'd0, got.valid});
      check_val("bd_D",    {31'd0, bd_D},    {31'd0, got.bd});
      check_val("exc_D",   {27'd0, exc_D},   {27'd0, got.exc});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rpc;
    model = '0;
    @(negedge clk);
    // reset for two cycles
    step(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h0000_3004, 32'h1111_1111, 1'b1);
    // normal load
    step(1'b0, 1'b0, 1'b1, 32'h0000_3004, 32'h3C01_1234, 1'b0);
    // stall three cycles with changing inputs
    step(1'b0, 1'b0, 1'b0, 32'h0000_3008, 32'hAAAA_0001, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0000_300C, 32'hAAAA_0002, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0000_3010, 32'hAAAA_0003, 1'b1);
    // release stall: current inputs load
    step(1'b0, 1'b0, 1'b1, 32'h0000_3014, 32'h2402_0005, 1'b0);
    // flush while stalled, then flush while loading
    step(1'b0, 1'b1, 1'b0, 32'h0000_3018, 32'h0000_1111, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_301C, 32'h0000_2222, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_3020, 32'h0000_3333, 1'b1);
    // AdEL cases and range boundaries
    step(1'b0, 1'b0, 1'b1, 32'h0000_3002, 32'h1234_5678, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_2FFC, 32'h1234_5678, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_6FFC, 32'h8765_4321, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_7000, 32'h8765_4321, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0C00_0C00, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h5555_5555, 1'b0);
    // delay slot: load with branch, then stall with branch dropped
    step(1'b0, 1'b0, 1'b1, 32'h0000_3100, 32'h0000_0021, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0000_3104, 32'h0000_0022, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_3104, 32'h0000_0022, 1'b0);
    // clr wins over flush and en
    step(1'b1, 1'b1, 1'b1, 32'h0000_3200, 32'h7777_7777, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h0000_3204, 32'h7777_7778, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'h0000_3208, 32'h7777_7779, 1'b1);
    // random traffic
    for (int i = 0; i < 60; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? $urandom() : (32'h0000_3000 + ($urandom_range(0, 16383)));
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
           rpc, $urandom(), $urandom_range(0, 1) == 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
